demux_4_salida: RTL and testbench
=================================

# demux_4_salida

Buffered 1-to-4 demultiplexer: the distributing counterpart of the datapath's 4:1 operand selectors. It takes one stream of WIDTH-bit words, each tagged with a 2-bit destination select, and routes each accepted word into one of four independent per-destination FIFOs. Each FIFO drains through its own valid/ready port. It sits between a single producer (writeback or store path) and up to four consumers (peripherals or functional units), so a stalled consumer never blocks traffic to the others.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 2, entries per destination FIFO; power of two, minimum 2
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  producer presents a word
- in_ready  output  1  block can accept the presented word
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination: 2'b00→port 0, 2'b01→port 1, 2'b10→port 2, 2'b11→port 3
- out_valid  output  4  bit n: port n FIFO non-empty
- out_ready  input  4  bit n: consumer n takes the head word
- out_data0..out_data3  output  WIDTH each  head word of FIFO n
- count0..count3  output  $clog2(DEPTH)+1 each  occupancy of FIFO n

## Operation
- Four identical FIFOs, each with a write pointer, a read pointer (log2 DEPTH bits, wrap modulo DEPTH), a count register, and DEPTH×WIDTH storage.
- in_ready = !full[in_sel], where full[n] = (countn == DEPTH). This is combinational on in_sel. It does not depend on in_valid or out_ready, so there is no ready-to-ready path.
- Push: in_valid && in_ready at a clock edge writes in_data at FIFO[in_sel] wptr. The wptr advances and the count increments. Only the selected FIFO changes.
- Pop n: out_valid[n] && out_ready[n] at a clock edge advances rptr n and decrements countn. out_ready[n] while empty has no effect.
- Simultaneous push and pop on the same FIFO, where it is neither empty nor full: count unchanged, both pointers advance.
- Push to a full FIFO cannot occur, because in_ready is low. A pop from it in the same cycle frees space that is visible to in_ready only on the next cycle.
- Pops on different ports in the same cycle are independent. Up to 4 pops plus 1 push can happen per cycle.
- out_valid[n] = (countn != 0). out_datan = storage[rptr n] when non-empty, and all-zeros when empty.
- Words to the same port leave in acceptance order. There is no ordering guarantee across ports.
- in_data and in_sel are don't-care while in_valid is low. Changing them while in_valid is high and in_ready is low is allowed; the values present at the accepting edge are used.

## Timing
- Reset, on the edge where rst=1: all pointers and counts go to 0, out_valid=4'b0000, out_data0..3=0, count0..3=0, in_ready=1 for any in_sel. Storage contents need not be cleared.
- rst overrides push and pop in the same cycle. A word offered during reset is not accepted and not stored.
- Reset mid-operation discards all buffered words.
- Latency: a word accepted at edge k appears on out_datan with out_valid[n]=1 immediately after edge k, so it can be popped at edge k+1.
- Throughput: 1 word/cycle into any one port while its consumer holds out_ready high, at DEPTH≥2.
- Pointer wrap: after DEPTH pushes, wptr returns to 0 with no bubble.

## Test plan
- Reset then idle: rst high 2 cycles → out_valid=0000, all counts 0, all out_data 0, in_ready=1 for each in_sel value.
- Routing: push 32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333 with in_sel 0,1,2,3 and all out_ready=0 → out_valid=1111, out_datan matches, each countn=1.
- Full/backpressure: out_ready=0000, push 3 words to port 2 → in_ready drops after 2 accepts, count2=2, third word held. Pulse out_ready[2] one cycle → count2=1, third word accepted next cycle.
- Isolation: port 1 full and stalled; push 8 words to port 3 with out_ready[3]=1 → all accepted back-to-back, port 3 output order 1..8, port 1 unchanged.
- Wrap and streaming: port 0 with out_ready[0]=1, push 10 consecutive words 32'd1..32'd10 → popped in order 1..10 at one per cycle after 1-cycle latency, count0 never exceeds 1.
- Reset mid-operation: fill ports 0 and 3, then assert rst in a cycle with in_valid=1 and out_ready=1111 → after the edge all counts 0, no pop counted, offered word absent.

Source files
------------

// File: rtl/demux_4_salida_if.sv
// demux_4_salida_if: bundles the producer stream and the four consumer ports of the demux.
// Ports: in_valid/in_ready/in_data/in_sel (producer side), out_valid/out_ready/out_data0..3/count0..3 (consumer side).
// Modports: slave is the demux's view, master is the surrounding producer/consumer view.
interface demux_4_salida_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;

    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [CW-1:0]    count0;
    logic [CW-1:0]    count1;
    logic [CW-1:0]    count2;
    logic [CW-1:0]    count3;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               count0, count1, count2, count3
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               count0, count1, count2, count3
    );
endinterface

// File: rtl/demux_4_salida.sv
// demux_4_salida: routes one tagged word stream into four independent per-destination FIFOs.
// Latency: a word accepted at edge k is at the head of its FIFO right after edge k.
// Backpressure: in_ready = !full[in_sel]; a stalled consumer only blocks words aimed at its own FIFO.
// Ports: clk, rst (sync, active-high), bus (demux_4_salida_if.slave: producer stream + 4 consumer ports).
module demux_4_salida #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    demux_4_salida_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wptr_q [4];
    logic [AW-1:0]    wptr_d [4];
    logic [AW-1:0]    rptr_q [4];
    logic [AW-1:0]    rptr_d [4];
    logic [CW-1:0]    count_q [4];
    logic [CW-1:0]    count_d [4];
    logic [WIDTH-1:0] mem_q [4][DEPTH];
    logic [WIDTH-1:0] mem_d [4][DEPTH];

    logic [3:0] full;
    logic [3:0] not_empty;
    logic [3:0] push;
    logic [3:0] pop;
    logic       accept;

    always_comb begin
        full      = '0;
        not_empty = '0;
        for (int n = 0; n < 4; n++) begin
            full[n]      = (count_q[n] == CW'(DEPTH));
            not_empty[n] = (count_q[n] != '0);
        end
    end

    // Ready only looks at the selected FIFO's stored occupancy, never at out_ready,
    // so a same-cycle pop frees space for the producer one cycle later.
    assign bus.in_ready = !full[bus.in_sel];
    assign accept       = bus.in_valid && bus.in_ready && !rst;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int n = 0; n < 4; n++) begin
            push[n] = accept && (bus.in_sel == n[1:0]);
            pop[n]  = bus.out_ready[n] && not_empty[n];
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int n = 0; n < 4; n++) begin
            wptr_d[n]  = wptr_q[n];
            rptr_d[n]  = rptr_q[n];
            count_d[n] = count_q[n];
            if (push[n]) begin
                mem_d[n][wptr_q[n]] = bus.in_data;
                wptr_d[n]           = wptr_q[n] + AW'(1);
            end
            if (pop[n]) begin
                rptr_d[n] = rptr_q[n] + AW'(1);
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push[n], pop[n]})
                2'b10:   count_d[n] = count_q[n] + CW'(1);
                2'b01:   count_d[n] = count_q[n] - CW'(1);
                default: count_d[n] = count_q[n];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                wptr_q[n]  <= '0;
                rptr_q[n]  <= '0;
                count_q[n] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not cleared on reset; the zeroed counts make stale entries invisible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = not_empty;
    assign bus.out_data0 = not_empty[0] ? mem_q[0][rptr_q[0]] : '0;
    assign bus.out_data1 = not_empty[1] ? mem_q[1][rptr_q[1]] : '0;
    assign bus.out_data2 = not_empty[2] ? mem_q[2][rptr_q[2]] : '0;
    assign bus.out_data3 = not_empty[3] ? mem_q[3][rptr_q[3]] : '0;
    assign bus.count0    = count_q[0];
    assign bus.count1    = count_q[1];
    assign bus.count2    = count_q[2];
    assign bus.count3    = count_q[3];
endmodule

// File: tb/tb_demux_4_salida.sv
// tb_demux_4_salida: directed bench for the 4-way buffered demux (WIDTH=32, DEPTH=2).
// Inputs change 2 time units after a rising edge; outputs are sampled in the same window.
// Ports exercised: every interface signal plus clk/rst.
module tb_demux_4_salida;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    demux_4_salida_if #(.WIDTH(32), .DEPTH(2)) bus ();

    demux_4_salida #(.WIDTH(32), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_data(input int n);
        case (n)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    function automatic logic [1:0] get_count(input int n);
        case (n)
            0:       return bus.count0;
            1:       return bus.count1;
            2:       return bus.count2;
            default: return bus.count3;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'h0;
        bus.out_ready = 4'b0000;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (get_count(n) !== 2'd0) begin
                errors++;
                $display("FAIL reset_count%0d: got %0d expected 0", n, get_count(n));
            end
            checks++;
            if (get_data(n) !== 32'h0) begin
                errors++;
                $display("FAIL reset_data%0d: got %h expected 0", n, get_data(n));
            end
            bus.in_sel = n[1:0];
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready_sel%0d: got %b expected 1", n, bus.in_ready);
            end
        end
    endtask

    task automatic test_routing();
        logic [31:0] words [4];
        words[0] = 32'hA0000000;
        words[1] = 32'hA1111111;
        words[2] = 32'hA2222222;
        words[3] = 32'hA3333333;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = n[1:0];
            bus.in_data  = words[n];
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            errors++;
            $display("FAIL route_out_valid: got %b expected 1111", bus.out_valid);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (get_data(n) !== words[n]) begin
                errors++;
                $display("FAIL route_data%0d: got %h expected %h", n, get_data(n), words[n]);
            end
            checks++;
            if (get_count(n) !== 2'd1) begin
                errors++;
                $display("FAIL route_count%0d: got %0d expected 1", n, get_count(n));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hC0000001;
        step();
        bus.in_data  = 32'hC0000002;
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_in_ready: got %b expected 0", bus.in_ready);
        end
        bus.in_data = 32'hC0000003;
        step();
        checks++;
        if (bus.count2 !== 2'd2) begin
            errors++;
            $display("FAIL full_count2_held: got %0d expected 2", bus.count2);
        end
        checks++;
        if (bus.out_data2 !== 32'hC0000001) begin
            errors++;
            $display("FAIL full_head2: got %h expected C0000001", bus.out_data2);
        end
        bus.in_sel = 2'd0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_other_ready: got %b expected 1", bus.in_ready);
        end
        bus.in_sel    = 2'd2;
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.count2 !== 2'd1) begin
            errors++;
            $display("FAIL full_count2_after_pop: got %0d expected 1", bus.count2);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count2 !== 2'd2) begin
            errors++;
            $display("FAIL full_count2_third_in: got %0d expected 2", bus.count2);
        end
        checks++;
        if (bus.out_data2 !== 32'hC0000002) begin
            errors++;
            $display("FAIL full_head2_second: got %h expected C0000002", bus.out_data2);
        end
        bus.out_ready = 4'b0100;
        step();
        checks++;
        if (bus.out_data2 !== 32'hC0000003) begin
            errors++;
            $display("FAIL full_head2_third: got %h expected C0000003", bus.out_data2);
        end
        step();
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid[2] !== 1'b0 || bus.out_data2 !== 32'h0) begin
            errors++;
            $display("FAIL full_drained: got valid=%b data=%h expected valid=0 data=0",
                     bus.out_valid[2], bus.out_data2);
        end
    endtask

    task automatic test_isolation();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 32'hB0000000;
        step();
        bus.in_data  = 32'hB0000001;
        step();
        bus.out_ready = 4'b1000;
        bus.in_sel    = 2'd3;
        for (int k = 1; k <= 8; k++) begin
            bus.in_data = 32'(k);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL iso_ready_word%0d: got %b expected 1", k, bus.in_ready);
            end
            step();
            checks++;
            if (bus.out_valid[3] !== 1'b1 || bus.out_data3 !== 32'(k)) begin
                errors++;
                $display("FAIL iso_port3_word%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, bus.out_valid[3], bus.out_data3, 32'(k));
            end
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.count3 !== 2'd0) begin
            errors++;
            $display("FAIL iso_count3_end: got %0d expected 0", bus.count3);
        end
        checks++;
        if (bus.count1 !== 2'd2 || bus.out_data1 !== 32'hB0000000) begin
            errors++;
            $display("FAIL iso_port1_kept: got count=%0d data=%h expected count=2 data=B0000000",
                     bus.count1, bus.out_data1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 4'b0001;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        for (int k = 1; k <= 10; k++) begin
            bus.in_data = 32'(k);
            step();
            checks++;
            if (bus.out_data0 !== 32'(k) || bus.count0 !== 2'd1) begin
                errors++;
                $display("FAIL stream_word%0d: got data=%h count=%0d expected data=%h count=1",
                         k, bus.out_data0, bus.count0, 32'(k));
            end
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.count0 !== 2'd0 || bus.out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: got count=%0d valid=%b expected 0 0",
                     bus.count0, bus.out_valid[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_sel  = (k < 2) ? 2'd0 : 2'd3;
            bus.in_data = 32'hD0000000 + 32'(k);
            step();
        end
        checks++;
        if (bus.count0 !== 2'd2 || bus.count3 !== 2'd2) begin
            errors++;
            $display("FAIL mid_prefill: got count0=%0d count3=%0d expected 2 2", bus.count0, bus.count3);
        end
        rst           = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 4'b1111;
        step();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (get_count(n) !== 2'd0) begin
                errors++;
                $display("FAIL mid_count%0d: got %0d expected 0", n, get_count(n));
            end
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b0000 || bus.out_data1 !== 32'h0) begin
            errors++;
            $display("FAIL mid_offered_absent: got valid=%b data1=%h expected 0000 0",
                     bus.out_valid, bus.out_data1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_routing();
        test_full();
        test_isolation();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
